// File: rtl/order_pkg.sv
// Shared types and helpers for the order gate and its buffer.
package order_pkg;

  // One buffered decision: type, id, price and volume (136 bits)
  typedef struct packed {
    logic [7:0]  ord_type;
    logic [63:0] order_id;
    logic [31:0] price;
    logic [31:0] volume;
  } order_t;

  // Gate sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } gate_state_e;

  // Width of the drop counters
  localparam int DROP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DROP_CNT_W-1:0] sat_inc16(input logic [DROP_CNT_W-1:0] v);
    logic [DROP_CNT_W-1:0] r;
    r = v;
    if (v != {DROP_CNT_W{1'b1}}) begin
      r = v + DROP_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/order_fifo.sv
// First-word fall-through FIFO holding pending orders. The head entry is
// visible combinationally whenever the buffer is not empty. Pushes into a
// full buffer and pops from an empty one are ignored here; the caller
// decides how to account for them.
module order_fifo
  import order_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = order_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  T                       i_push_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents are only meaningful while counted, so no reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/order_gate.sv
// Risk and sequencing gate between trading logic and the transmit path.
// Decision pulses are buffered, checked against a cumulative position cap
// and a token-bucket rate limit, and released one at a time over a
// valid/ready handshake. The order stays at the FIFO head until it is either
// rejected or handshaken, so a waiting or presented order keeps its slot.
module order_gate
  import order_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int TOKENS_MAX    = 8,
  parameter int REFILL_CYCLES = 1000,
  parameter int MAX_POSITION  = 100000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            in_valid,
  input  logic [7:0]                      in_type,
  input  logic [63:0]                     in_order_id,
  input  logic [31:0]                     in_price,
  input  logic [31:0]                     in_volume,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      out_type,
  output logic [63:0]                     out_order_id,
  output logic [31:0]                     out_price,
  output logic [31:0]                     out_volume,
  output logic [47:0]                     position,
  output logic [$clog2(TOKENS_MAX+1)-1:0] tokens,
  output logic [15:0]                     drop_full_cnt,
  output logic [15:0]                     drop_risk_cnt
);

  localparam int TW = $clog2(TOKENS_MAX + 1);
  localparam int RW = $clog2(REFILL_CYCLES);
  localparam int CW = $clog2(DEPTH) + 1;

  gate_state_e    r_state;
  gate_state_e    w_next_state;

  order_t         r_out;
  logic           r_out_valid;
  logic [47:0]    r_position;
  logic [TW-1:0]  r_tokens;
  logic [RW-1:0]  r_refill_cnt;
  logic [15:0]    r_drop_full;
  logic [15:0]    r_drop_risk;

  order_t         w_push_data;
  order_t         w_head;
  logic           w_push;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [CW-1:0]  w_fifo_count;
  logic           w_drop_full;

  logic [48:0]    w_pos_sum;
  logic           w_risk_ok;
  logic           w_refill;

  logic           w_pop;
  logic           w_consume;
  logic           w_load_out;
  logic           w_risk_drop;
  logic           w_accept;

  assign w_push      = in_valid && enable;
  assign w_drop_full = w_push && w_fifo_full;
  assign w_push_data = order_t'{in_type, in_order_id, in_price, in_volume};

  order_fifo #(
    .DEPTH (DEPTH),
    .T     (order_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Position check is done one bit wider than the accumulator so it cannot wrap
  assign w_pos_sum = {1'b0, r_position} + {17'b0, w_head.volume};
  assign w_risk_ok = (w_head.volume != 32'd0) && (w_pos_sum <= 49'(MAX_POSITION));

  assign w_refill  = (r_refill_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-cycle actions; risk is re-evaluated every CHECK cycle
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_consume    = 1'b0;
    w_load_out   = 1'b0;
    w_risk_drop  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !w_fifo_empty) begin
          w_next_state = CHECK;
        end
      end
      CHECK: begin
        if (w_fifo_count == '0) begin
          w_next_state = IDLE;
        end else if (!w_risk_ok) begin
          w_pop        = 1'b1;
          w_risk_drop  = 1'b1;
          w_next_state = IDLE;
        end else if (r_tokens != '0) begin
          w_consume    = 1'b1;
          w_load_out   = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          w_pop        = 1'b1;
          w_accept     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Presented order: captured on CHECK->SEND, held until the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      r_out       <= w_head;
      r_out_valid <= 1'b1;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  // Token bucket: periodic refill, one token per released order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refill_cnt <= RW'(REFILL_CYCLES - 1);
      r_tokens     <= TW'(TOKENS_MAX);
    end else begin
      if (w_refill) begin
        r_refill_cnt <= RW'(REFILL_CYCLES - 1);
      end else begin
        r_refill_cnt <= r_refill_cnt - RW'(1);
      end
      case ({w_refill, w_consume})
        2'b10: begin
          if (r_tokens < TW'(TOKENS_MAX)) begin
            r_tokens <= r_tokens + TW'(1);
          end
        end
        2'b01:   r_tokens <= r_tokens - TW'(1);
        default: r_tokens <= r_tokens;
      endcase
    end
  end

  // Cumulative volume of handshaken orders
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_position <= '0;
    end else if (w_accept) begin
      r_position <= r_position + 48'(r_out.volume);
    end
  end

  // Saturating drop counters for overflow and risk rejects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_full <= '0;
      r_drop_risk <= '0;
    end else begin
      if (w_drop_full) begin
        r_drop_full <= sat_inc16(r_drop_full);
      end
      if (w_risk_drop) begin
        r_drop_risk <= sat_inc16(r_drop_risk);
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_type      = r_out.ord_type;
  assign out_order_id  = r_out.order_id;
  assign out_price     = r_out.price;
  assign out_volume    = r_out.volume;
  assign position      = r_position;
  assign tokens        = r_tokens;
  assign drop_full_cnt = r_drop_full;
  assign drop_risk_cnt = r_drop_risk;

endmodule

// File: tb/tb_order_gate.sv
// Directed bench for order_gate with a small bucket (2 tokens, refill every
// 20 cycles) and a 1000-unit position cap so that rate and risk limits are
// reached within a few orders. Every scenario starts from a fresh reset; edge
// numbers in comments count rising edges after reset release (E1 is the first).
module tb_order_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic [7:0]  in_type;
  logic [63:0] in_order_id;
  logic [31:0] in_price;
  logic [31:0] in_volume;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_type;
  logic [63:0] out_order_id;
  logic [31:0] out_price;
  logic [31:0] out_volume;
  logic [47:0] position;
  logic [1:0]  tokens;
  logic [15:0] drop_full_cnt;
  logic [15:0] drop_risk_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] drainIds [4];
  logic        anySeen;
  int          waited;

  order_gate #(
    .DEPTH         (4),
    .TOKENS_MAX    (2),
    .REFILL_CYCLES (20),
    .MAX_POSITION  (1000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_type       (in_type),
    .in_order_id   (in_order_id),
    .in_price      (in_price),
    .in_volume     (in_volume),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_type      (out_type),
    .out_order_id  (out_order_id),
    .out_price     (out_price),
    .out_volume    (out_volume),
    .position      (position),
    .tokens        (tokens),
    .drop_full_cnt (drop_full_cnt),
    .drop_risk_cnt (drop_risk_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] id,
                               input logic [31:0] price, input logic [31:0] vol);
    in_valid    = v;
    in_type     = 8'h42;
    in_order_id = id;
    in_price    = price;
    in_volume   = vol;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle decision pulse, consumes one edge
  task automatic pulse(input logic [63:0] id, input logic [31:0] price,
                       input logic [31:0] vol);
    applyStimulus(1'b1, id, price, vol);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    drainIds[0] = 64'd23;
    drainIds[1] = 64'd24;
    drainIds[2] = 64'd25;
    drainIds[3] = 64'd26;
    rst_n     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 64'd0, 32'd0, 32'd0);

    // Reset values
    doReset();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_id", out_order_id, 0);
    checkOutput("rst_position", position, 0);
    checkOutput("rst_tokens", tokens, 2);
    checkOutput("rst_drop_full", drop_full_cnt, 0);
    checkOutput("rst_drop_risk", drop_risk_cnt, 0);

    // Single order: out_valid three cycles after the pulse, for one cycle
    out_ready = 1'b1;
    pulse(64'd1, 32'd9000, 32'd100);                    // E1 push
    checkOutput("single_e1_valid", out_valid, 0);
    tick();                                              // E2 -> CHECK
    checkOutput("single_e2_valid", out_valid, 0);
    tick();                                              // E3 -> SEND
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_type", out_type, 8'h42);
    checkOutput("single_id", out_order_id, 1);
    checkOutput("single_price", out_price, 9000);
    checkOutput("single_volume", out_volume, 100);
    checkOutput("single_tokens_send", tokens, 1);
    tick();                                              // E4 handshake
    checkOutput("single_valid_drop", out_valid, 0);
    checkOutput("single_position", position, 100);
    checkOutput("single_tokens", tokens, 1);

    // Backpressure: order held stable, position bumps once on release
    doReset();
    out_ready = 1'b0;
    pulse(64'd2, 32'd5000, 32'd250);                    // E1
    tick();                                              // E2
    tick();                                              // E3
    checkOutput("bp_valid_start", out_valid, 1);
    for (int i = 0; i < 10; i++) begin                   // E4..E13
      tick();
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_id", out_order_id, 2);
      checkOutput("bp_hold_volume", out_volume, 250);
      checkOutput("bp_hold_position", position, 0);
    end
    out_ready = 1'b1;
    tick();                                              // E14 handshake
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_position", position, 250);
    tick();
    tick();                                              // E16
    checkOutput("bp_position_once", position, 250);
    checkOutput("bp_tokens", tokens, 1);

    // Risk: 600 accepted, 500 rejected, zero rejected, 400 exactly fills the cap
    doReset();
    out_ready = 1'b1;
    pulse(64'd3, 32'd100, 32'd600);                     // E1
    tick();
    tick();                                              // E3
    checkOutput("risk_first_valid", out_valid, 1);
    tick();                                              // E4
    checkOutput("risk_first_position", position, 600);
    pulse(64'd4, 32'd100, 32'd500);                     // E5
    tick();                                              // E6 CHECK
    tick();                                              // E7 reject
    checkOutput("risk_over_cnt", drop_risk_cnt, 1);
    checkOutput("risk_over_valid", out_valid, 0);
    checkOutput("risk_over_position", position, 600);
    pulse(64'd5, 32'd100, 32'd0);                       // E8
    tick();
    tick();                                              // E10 reject
    checkOutput("risk_zero_cnt", drop_risk_cnt, 2);
    pulse(64'd6, 32'd100, 32'd400);                     // E11
    tick();
    tick();                                              // E13 SEND
    checkOutput("risk_cap_valid", out_valid, 1);
    checkOutput("risk_cap_id", out_order_id, 6);
    tick();                                              // E14
    checkOutput("risk_cap_position", position, 1000);
    checkOutput("risk_cap_tokens", tokens, 0);
    pulse(64'd7, 32'd100, 32'd1);                       // E15
    tick();
    tick();                                              // E17 reject despite no tokens
    checkOutput("risk_plus1_cnt", drop_risk_cnt, 3);
    checkOutput("risk_plus1_valid", out_valid, 0);
    checkOutput("risk_plus1_position", position, 1000);

    // Rate limit: third order waits for the refill on E20, sent on E21
    doReset();
    out_ready = 1'b1;
    pulse(64'd11, 32'd1, 32'd10);                       // E1
    pulse(64'd12, 32'd1, 32'd10);                       // E2
    pulse(64'd13, 32'd1, 32'd10);                       // E3
    checkOutput("rate_o1_valid", out_valid, 1);
    checkOutput("rate_o1_id", out_order_id, 11);
    checkOutput("rate_o1_tokens", tokens, 1);
    tick();                                              // E4
    checkOutput("rate_gap1_valid", out_valid, 0);
    tick();                                              // E5
    checkOutput("rate_gap2_valid", out_valid, 0);
    tick();                                              // E6 three-cycle spacing
    checkOutput("rate_o2_valid", out_valid, 1);
    checkOutput("rate_o2_id", out_order_id, 12);
    checkOutput("rate_o2_tokens", tokens, 0);
    anySeen = 1'b0;
    for (int i = 0; i < 13; i++) begin                   // E7..E19
      tick();
      if (i > 0 && out_valid) anySeen = 1'b1;
    end
    checkOutput("rate_wait_valid", anySeen, 0);
    checkOutput("rate_wait_tokens", tokens, 0);
    checkOutput("rate_wait_position", position, 20);
    tick();                                              // E20 refill
    checkOutput("rate_refill_tokens", tokens, 1);
    checkOutput("rate_refill_valid", out_valid, 0);
    tick();                                              // E21
    checkOutput("rate_o3_valid", out_valid, 1);
    checkOutput("rate_o3_id", out_order_id, 13);
    checkOutput("rate_o3_tokens", tokens, 0);

    // Overflow: head waits for a token while five more pulses arrive
    doReset();
    out_ready = 1'b1;
    pulse(64'd21, 32'd1, 32'd10);                       // E1
    pulse(64'd22, 32'd1, 32'd10);                       // E2
    pulse(64'd23, 32'd1, 32'd10);                       // E3
    tick();
    tick();
    tick();
    tick();                                              // E7, order 23 alone in FIFO
    checkOutput("ovf_pre_position", position, 20);
    pulse(64'd24, 32'd1, 32'd10);                       // E8 count 2
    pulse(64'd25, 32'd1, 32'd10);                       // E9 count 3
    pulse(64'd26, 32'd1, 32'd10);                       // E10 count 4
    checkOutput("ovf_full_nodrop", drop_full_cnt, 0);
    pulse(64'd27, 32'd1, 32'd10);                       // E11 dropped
    checkOutput("ovf_drop1", drop_full_cnt, 1);
    pulse(64'd28, 32'd1, 32'd10);                       // E12 dropped
    checkOutput("ovf_drop2", drop_full_cnt, 2);
    checkOutput("ovf_wait_valid", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (out_valid !== 1'b1 && waited < 50) begin
        tick();
        waited++;
      end
      checkOutput("ovf_drain_in_time", (waited < 50), 1);
      checkOutput("ovf_drain_id", out_order_id, drainIds[k]);
      tick();
    end
    anySeen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (out_valid) anySeen = 1'b1;
    end
    checkOutput("ovf_no_extra", anySeen, 0);
    checkOutput("ovf_final_position", position, 60);
    checkOutput("ovf_final_drop", drop_full_cnt, 2);

    // Enable low: pulses ignored entirely
    doReset();
    enable    = 1'b0;
    out_ready = 1'b1;
    pulse(64'd31, 32'd1, 32'd10);                       // E1 ignored
    anySeen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) anySeen = 1'b1;
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) anySeen = 1'b1;
    end
    checkOutput("en_no_output", anySeen, 0);
    checkOutput("en_drop_full", drop_full_cnt, 0);
    checkOutput("en_position", position, 0);
    checkOutput("en_tokens", tokens, 2);

    // Reset during SEND: outputs clear immediately, buffered order discarded
    doReset();
    out_ready = 1'b0;
    pulse(64'd41, 32'd7, 32'd50);                       // E1
    pulse(64'd42, 32'd7, 32'd60);                       // E2
    tick();                                              // E3 SEND
    checkOutput("mid_valid_before", out_valid, 1);
    checkOutput("mid_id_before", out_order_id, 41);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_async_valid", out_valid, 0);
    checkOutput("mid_async_id", out_order_id, 0);
    checkOutput("mid_async_volume", out_volume, 0);
    checkOutput("mid_async_tokens", tokens, 2);
    checkOutput("mid_async_position", position, 0);
    tick();
    rst_n = 1'b1;
    anySeen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) anySeen = 1'b1;
    end
    checkOutput("mid_fifo_empty", anySeen, 0);
    checkOutput("mid_tokens_after", tokens, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
